bam_mac_accumulator: RTL and testbench

- Accumulator stage directly downstream of the BAM approximate multiplier wrapper inside an APTPU processing element.
- Consumes one unsigned BAM product per accepted beat and sums ACC_LEN consecutive products into one dot-product partial sum.
- Presents each completed sum on a one-deep registered valid/ready output toward the PE output or column-reduction path.
- Partial accumulation continues while a completed result waits downstream; only the closing product of the next group can stall.

---
 rtl/bam_mac_accumulator.sv | 76 +++++++
 tb/tb_bam_mac_accumulator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bam_mac_accumulator.sv
// Sums ACC_LEN unsigned BAM products into one dot-product partial sum.
// The result is presented through a one-deep registered valid/ready output.
module bam_mac_accumulator #(
    parameter int DW      = 8,
    parameter int WW      = 8,
    parameter int ACC_LEN = 16,
    localparam int PW     = DW + WW,
    localparam int CW     = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1,
    localparam int AW     = PW + CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_prod,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic [CW-1:0] part_cnt
);

    logic [AW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_valid;
    logic [AW-1:0] r_sum;

    logic          w_is_last;
    logic          w_first;
    logic          w_acc_fire;
    logic          w_out_fire;
    logic [AW-1:0] w_sum;

    assign w_is_last  = (r_cnt == CW'(ACC_LEN - 1));
    assign w_first    = (r_cnt == '0);
    // Only the closing product waits on a held result; partial sums keep flowing.
    assign in_ready   = !clr && !(w_is_last && r_valid && !out_ready);
    assign w_acc_fire = in_valid && in_ready;
    assign w_out_fire = r_valid && out_ready;
    assign w_sum      = w_first ? AW'(in_prod) : (r_acc + AW'(in_prod));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_acc_fire) begin
            if (w_is_last) begin
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // A closing accept in the same cycle as a drain reloads without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
        end else if (w_acc_fire && w_is_last) begin
            r_valid <= 1'b1;
            r_sum   <= w_sum;
        end else if (w_out_fire) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_sum   = r_sum;
    assign part_cnt  = r_cnt;

endmodule

// File: tb/tb_bam_mac_accumulator.sv
// Scoreboard bench: stimulus pushes expected sums, negedge monitors pop on drain.
module tb_bam_mac_accumulator;

    logic clk;
    logic rst;

    logic        clr4, iv4, ir4, ov4, or4;
    logic [15:0] ip4;
    logic [17:0] os4;
    logic [1:0]  pc4;

    logic        clr1, iv1, ir1, ov1, or1;
    logic [15:0] ip1;
    logic [16:0] os1;
    logic [0:0]  pc1;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] q4[$];
    logic [31:0] q1[$];

    bam_mac_accumulator #(.DW(8), .WW(8), .ACC_LEN(4)) u_dut4 (
        .clk(clk), .rst(rst), .clr(clr4), .in_valid(iv4), .in_ready(ir4),
        .in_prod(ip4), .out_valid(ov4), .out_ready(or4), .out_sum(os4),
        .part_cnt(pc4)
    );

    bam_mac_accumulator #(.DW(8), .WW(8), .ACC_LEN(1)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr1), .in_valid(iv1), .in_ready(ir1),
        .in_prod(ip1), .out_valid(ov1), .out_ready(or1), .out_sum(os1),
        .part_cnt(pc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!rst && ov4 && or4) begin
            if (q4.size() == 0) begin
                n_checks++;
                $display("FAIL sum4_unexpected: got %0d expected no result", os4);
            end else begin
                chk("sum4", 32'(os4), q4.pop_front());
            end
        end
        if (!rst && ov1 && or1) begin
            if (q1.size() == 0) begin
                n_checks++;
                $display("FAIL sum1_unexpected: got %0d expected no result", os1);
            end else begin
                chk("sum1", 32'(os1), q1.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One product to the ACC_LEN=4 instance, checking it is accepted.
    task automatic beat4(input logic [15:0] p);
        iv4 = 1'b1;
        ip4 = p;
        #1;
        chk("in_ready4", 32'(ir4), 32'd1);
        step();
        iv4 = 1'b0;
    endtask

    task automatic beat1(input logic [15:0] p);
        iv1 = 1'b1;
        ip1 = p;
        #1;
        chk("in_ready1", 32'(ir1), 32'd1);
        step();
        iv1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clr4 = 1'b0; iv4 = 1'b0; ip4 = '0; or4 = 1'b1;
        clr1 = 1'b0; iv1 = 1'b0; ip1 = '0; or1 = 1'b1;
        step();
        step();
        rst = 1'b0;

        chk("rst_in_ready", 32'(ir4), 32'd1);
        chk("rst_out_valid", 32'(ov4), 32'd0);
        chk("rst_out_sum", 32'(os4), 32'd0);
        chk("rst_part_cnt", 32'(pc4), 32'd0);

        // 1,2,3,4 -> 10
        for (int i = 0; i < 4; i++) begin
            chk("t1_part_cnt", 32'(pc4), 32'(i));
            if (i == 3) q4.push_back(32'd10);
            beat4(16'(i + 1));
        end
        chk("t1_valid", 32'(ov4), 32'd1);
        chk("t1_sum", 32'(os4), 32'd10);
        chk("t1_cnt_wrap", 32'(pc4), 32'd0);
        step();
        chk("t1_valid_drop", 32'(ov4), 32'd0);

        // 8 x 65535 back to back
        for (int i = 0; i < 8; i++) begin
            if (i == 3 || i == 7) q4.push_back(32'd262140);
            beat4(16'hFFFF);
            if (i == 3 || i == 7) begin
                chk("t2_valid", 32'(ov4), 32'd1);
                chk("t2_sum", 32'(os4), 32'd262140);
            end
        end
        step();

        // backpressure: result 10 held, closing product 8 stalls
        or4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) q4.push_back(32'd10);
            beat4(16'(i + 1));
        end
        for (int i = 0; i < 3; i++) beat4(16'(i + 5));
        chk("t3_part_cnt", 32'(pc4), 32'd3);
        iv4 = 1'b1;
        ip4 = 16'd8;
        #1;
        chk("t3_stall", 32'(ir4), 32'd0);
        step();
        chk("t3_hold_cnt", 32'(pc4), 32'd3);
        chk("t3_hold_valid", 32'(ov4), 32'd1);
        chk("t3_hold_sum", 32'(os4), 32'd10);
        or4 = 1'b1;
        #1;
        chk("t3_release", 32'(ir4), 32'd1);
        q4.push_back(32'd26);
        step();
        iv4 = 1'b0;
        chk("t3_valid", 32'(ov4), 32'd1);
        chk("t3_sum", 32'(os4), 32'd26);
        step();
        chk("t3_drain", 32'(ov4), 32'd0);

        // clr aborts partial 9+9 and blocks the 100
        beat4(16'd9);
        beat4(16'd9);
        clr4 = 1'b1;
        iv4 = 1'b1;
        ip4 = 16'd100;
        #1;
        chk("t4_clr_ready", 32'(ir4), 32'd0);
        step();
        clr4 = 1'b0;
        iv4 = 1'b0;
        chk("t4_clr_cnt", 32'(pc4), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) q4.push_back(32'd4);
            beat4(16'd1);
        end
        chk("t4_sum", 32'(os4), 32'd4);
        step();

        // ACC_LEN=1: every product is a result
        chk("t5_cnt", 32'(pc1), 32'd0);
        q1.push_back(32'd7);
        beat1(16'd7);
        chk("t5_valid_a", 32'(ov1), 32'd1);
        chk("t5_sum_a", 32'(os1), 32'd7);
        q1.push_back(32'd300);
        beat1(16'd300);
        chk("t5_valid_b", 32'(ov1), 32'd1);
        chk("t5_sum_b", 32'(os1), 32'd300);
        step();
        chk("t5_drain", 32'(ov1), 32'd0);

        // reset discards held result and partial group
        or4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) q4.push_back(32'd10);
            beat4(16'(i + 1));
        end
        beat4(16'd2);
        beat4(16'd2);
        chk("t6_pre_cnt", 32'(pc4), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        q4.delete();
        chk("t6_valid", 32'(ov4), 32'd0);
        chk("t6_sum", 32'(os4), 32'd0);
        chk("t6_cnt", 32'(pc4), 32'd0);
        or4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) q4.push_back(32'd8);
            beat4(16'd2);
        end
        chk("t6_sum_after", 32'(os4), 32'd8);
        step();
        step();

        chk("q4_empty", 32'(q4.size()), 32'd0);
        chk("q1_empty", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
